turn_scheduler: RTL and testbench
=================================

# turn_scheduler

Game-flow controller between the debounced player buttons and the battleship board datapath. Enforces placement and shot turn order, arbitrates simultaneous player requests, and issues place/fire commands to the board over a valid/ready command channel. It applies hit/miss responses to per-player scores and declares the winner. It runs on the divided clock alongside the debouncers and drives the phase and score fields the display path renders.

## Interface
- SHIPS, 4: ships each player places before shooting starts (1..7)
- WIN_SCORE, 4: hits needed to win (1..7, ≤ SHIPS)
- SHOW_CYC, 50: cycles the result phase is held before the turn passes (≥1)
- TIMEOUT_CYC, 500: idle-turn limit; used only with SHOT_TIMEOUT_EN
- clk  in  1  divided game clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle start pulse
- pA_req, pB_req  in  1  one-cycle debounced fire/place pulses
- coord  in  4  {X[1:0],Y[1:0]}, sampled on request acceptance
- cmd_valid  out  1  command pending
- cmd_ready  in  1  board accepts command
- cmd_op  out  1  0 = place, 1 = fire
- cmd_player  out  1  0 = A, 1 = B
- cmd_coord  out  4  latched coordinate
- rsp_valid  in  1  board response strobe
- rsp_code  in  2  00 ok/miss, 01 hit, 10 illegal, 11 treated as illegal
- phase  out  3  state code (package enum)
- turn  out  1  player whose input is accepted
- last_hit  out  1  result of the last completed shot
- scoreA, scoreB  out  3  hit counts
- winner_valid  out  1  game over
- winner  out  1  0 = A, 1 = B

## Operation
- States: IDLE, PLACE, SHOT, ISSUE, WAIT_RSP, SHOW, DONE. Placement vs. shot is tracked by a mode bit; the acting player is the `turn` bit.
- IDLE: on `start`, go to PLACE with turn = A and all counters cleared.
- PLACE/SHOT: only the request of the player named by `turn` is accepted. The other player's pulse is dropped, including when both pulse in the same cycle. There is no queuing.
- Acceptance: latch coord, op, and player; go to ISSUE.
- ISSUE: hold cmd_valid and a stable payload until the cycle where cmd_valid && cmd_ready; then go to WAIT_RSP.
- WAIT_RSP: wait for rsp_valid. rsp_valid in any other state is ignored.
- Placement response:
  - ok increments the player's place count. At SHIPS, A hands over to B (PLACE, turn = B); B hands over to shooting (SHOT, turn = A).
  - illegal returns to PLACE with the same player and no count change.
- Shot response:
  - hit sets last_hit = 1 and increments the shooter's score (saturating at 7). If the score equals WIN_SCORE, go to DONE.
  - miss sets last_hit = 0.
  - After hit-without-win or miss, go to SHOW. After SHOW_CYC cycles, go to SHOT with turn toggled.
  - illegal returns to SHOT with the same shooter; score and last_hit are unchanged.
- DONE: winner_valid = 1 and winner = shooter, held. `start` restarts to PLACE with everything cleared. Requests are ignored.
- `start` in any state other than IDLE and DONE is ignored.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, turn 0, cmd_valid 0, cmd_op 0, cmd_player 0, cmd_coord 0, last_hit 0, scores 0, winner_valid 0, winner 0.
- A request accepted at edge N gives cmd_valid = 1 from cycle N+1.
- With cmd_ready already high, the handshake completes at edge N+1 and WAIT_RSP begins at N+2.
- rsp_valid sampled at edge M: score, turn, and phase updates are visible at cycle M+1.
- SHOW lasts exactly SHOW_CYC cycles.
- Reset mid-transaction drops cmd_valid immediately. The board must tolerate the abandoned command.

## Configuration
- SHOT_TIMEOUT_EN defined:
  - In SHOT only, a counter runs from turn entry.
  - If it reaches TIMEOUT_CYC without an accepted request, the turn toggles with no command issued and no score change.
  - The counter restarts on every SHOT entry.
- SHOT_TIMEOUT_EN undefined: no counter is instantiated and SHOT waits indefinitely. TIMEOUT_CYC is unused.

## Structure
- battleship_pkg holds:
  - the phase state enum
  - OP_PLACE/OP_FIRE
  - RSP_OK/RSP_HIT/RSP_ILLEGAL
  - PLAYER_A/PLAYER_B
- Sub-module hold_timer: loadable down-counter with a done flag. It is used for SHOW, and a second instance is used for the timeout when SHOT_TIMEOUT_EN is defined.

## Test plan
- Placement sequencing: SHIPS=4; start, then 4 pA_req each answered ok → phase moves to PLACE with turn = B. pA_req during B placement produces no cmd_valid.
- Simultaneous requests: in SHOT with turn = A, pA_req and pB_req in the same cycle → exactly one command with cmd_player = 0 and the latched coord (e.g. 4'b1001).
- Backpressure: cmd_ready low for 5 cycles → cmd_valid and payload stable for all 5 cycles. Handshake completes on the first cycle ready is high, and exactly one command is issued.
- Hit/miss/illegal: A hit → scoreA = 1, last_hit = 1, SHOW held 50 cycles, then turn = B. B illegal → turn stays B with scores unchanged. B miss → turn = A.
- Win: A reaches 4 hits → winner_valid = 1 and winner = 0, held; requests are ignored; start → PLACE with scores 0.
- Reset and timeout: rst low during WAIT_RSP → all outputs at their reset values in the same cycle. With SHOT_TIMEOUT_EN and TIMEOUT_CYC = 10, 10 idle cycles in SHOT → turn toggles with no command issued.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared types and encodings for the battleship game-flow controller.
package battleship_pkg;

    // Phase codes, driven straight onto the phase output.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPlace   = 3'd1,
        StShot    = 3'd2,
        StIssue   = 3'd3,
        StWaitRsp = 3'd4,
        StShow    = 3'd5,
        StDone    = 3'd6
    } phase_e;

    localparam logic OP_PLACE = 1'b0;
    localparam logic OP_FIRE  = 1'b1;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_HIT     = 2'b01;
    localparam logic [1:0] RSP_ILLEGAL = 2'b10;

    localparam logic PLAYER_A = 1'b0;
    localparam logic PLAYER_B = 1'b1;

    // Score increment that sticks at the 3-bit maximum.
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter; done is high once the count has reached zero.
module hold_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic             done
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Load has priority; otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/turn_scheduler.sv
// Battleship turn scheduler: placement/shot turn order, command issue to the
// board over valid/ready, score keeping and winner detection.
// Optional feature: define SHOT_TIMEOUT_EN to pass an idle shot turn after
// TIMEOUT_CYC cycles.
module turn_scheduler
    import battleship_pkg::*;
#(
    parameter int unsigned SHIPS       = 4,
    parameter int unsigned WIN_SCORE   = 4,
    parameter int unsigned SHOW_CYC    = 50,
    parameter int unsigned TIMEOUT_CYC = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pA_req,
    input  logic       pB_req,
    input  logic [3:0] coord,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_op,
    output logic       cmd_player,
    output logic [3:0] cmd_coord,
    input  logic       rsp_valid,
    input  logic [1:0] rsp_code,
    output logic [2:0] phase,
    output logic       turn,
    output logic       last_hit,
    output logic [2:0] scoreA,
    output logic [2:0] scoreB,
    output logic       winner_valid,
    output logic       winner
);

    localparam int unsigned ShowW = $clog2(SHOW_CYC + 1);

    phase_e     state_q, state_d;
    logic       mode_q, mode_d;  // 0 = placement, 1 = shooting
    logic       turn_q, turn_d;
    logic [2:0] place_cnt_q, place_cnt_d;
    logic       op_q, op_d;
    logic       player_q, player_d;
    logic [3:0] coord_q, coord_d;
    logic       last_hit_q, last_hit_d;
    logic [2:0] score_a_q, score_a_d;
    logic [2:0] score_b_q, score_b_d;
    logic       win_valid_q, win_valid_d;
    logic       win_q, win_d;

    logic       req_accept;
    logic       restart;
    logic       show_load;
    logic       show_done;
    logic       timeout_fire;
    logic [2:0] place_next;
    logic [2:0] shooter_next;

    assign req_accept   = ((state_q == StPlace) || (state_q == StShot)) &&
                          (turn_q ? pB_req : pA_req);
    assign place_next   = place_cnt_q + 3'd1;
    assign shooter_next = sat_inc3(turn_q ? score_b_q : score_a_q);

    hold_timer #(
        .Width(ShowW)
    ) u_show_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (show_load),
        .load_val(ShowW'(SHOW_CYC - 1)),
        .done    (show_done)
    );

`ifdef SHOT_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);

    logic to_load;
    logic to_done;

    // Reload on every SHOT entry, including the re-entry after a timeout pass.
    assign to_load      = (state_d == StShot) && ((state_q != StShot) || timeout_fire);
    assign timeout_fire = (state_q == StShot) && to_done && !req_accept;

    hold_timer #(
        .Width(ToW)
    ) u_timeout_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (to_load),
        .load_val(ToW'(TIMEOUT_CYC - 1)),
        .done    (to_done)
    );
`else
    // Without the timeout feature SHOT waits indefinitely; TIMEOUT_CYC has no effect.
    assign timeout_fire = (TIMEOUT_CYC == 0) && 1'b0;
`endif

    // Next-state and datapath update for the game-flow FSM.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        turn_d      = turn_q;
        place_cnt_d = place_cnt_q;
        op_d        = op_q;
        player_d    = player_q;
        coord_d     = coord_q;
        last_hit_d  = last_hit_q;
        score_a_d   = score_a_q;
        score_b_d   = score_b_q;
        win_valid_d = win_valid_q;
        win_d       = win_q;
        restart     = 1'b0;
        show_load   = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                restart = start;
            end
            StPlace, StShot: begin
                if (req_accept) begin
                    coord_d  = coord;
                    op_d     = mode_q ? OP_FIRE : OP_PLACE;
                    player_d = turn_q;
                    state_d  = StIssue;
                end else if (timeout_fire) begin
                    turn_d = ~turn_q;
                end
            end
            StIssue: begin
                if (cmd_ready) begin
                    state_d = StWaitRsp;
                end
            end
            StWaitRsp: begin
                if (rsp_valid) begin
                    if (!mode_q) begin
                        state_d = StPlace;
                        if (rsp_code == RSP_OK) begin
                            if (place_next == 3'(SHIPS)) begin
                                place_cnt_d = 3'd0;
                                if (turn_q == PLAYER_A) begin
                                    turn_d = PLAYER_B;
                                end else begin
                                    mode_d  = 1'b1;
                                    turn_d  = PLAYER_A;
                                    state_d = StShot;
                                end
                            end else begin
                                place_cnt_d = place_next;
                            end
                        end
                    end else begin
                        case (rsp_code)
                            RSP_OK: begin
                                last_hit_d = 1'b0;
                                state_d    = StShow;
                                show_load  = 1'b1;
                            end
                            RSP_HIT: begin
                                last_hit_d = 1'b1;
                                if (turn_q) begin
                                    score_b_d = shooter_next;
                                end else begin
                                    score_a_d = shooter_next;
                                end
                                if (shooter_next == 3'(WIN_SCORE)) begin
                                    win_valid_d = 1'b1;
                                    win_d       = turn_q;
                                    state_d     = StDone;
                                end else begin
                                    state_d   = StShow;
                                    show_load = 1'b1;
                                end
                            end
                            default: begin
                                state_d = StShot;
                            end
                        endcase
                    end
                end
            end
            StShow: begin
                if (show_done) begin
                    state_d = StShot;
                    turn_d  = ~turn_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (restart) begin
            state_d     = StPlace;
            mode_d      = 1'b0;
            turn_d      = PLAYER_A;
            place_cnt_d = 3'd0;
            last_hit_d  = 1'b0;
            score_a_d   = 3'd0;
            score_b_d   = 3'd0;
            win_valid_d = 1'b0;
            win_d       = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            turn_q      <= 1'b0;
            place_cnt_q <= 3'd0;
            op_q        <= 1'b0;
            player_q    <= 1'b0;
            coord_q     <= 4'd0;
            last_hit_q  <= 1'b0;
            score_a_q   <= 3'd0;
            score_b_q   <= 3'd0;
            win_valid_q <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            turn_q      <= turn_d;
            place_cnt_q <= place_cnt_d;
            op_q        <= op_d;
            player_q    <= player_d;
            coord_q     <= coord_d;
            last_hit_q  <= last_hit_d;
            score_a_q   <= score_a_d;
            score_b_q   <= score_b_d;
            win_valid_q <= win_valid_d;
            win_q       <= win_d;
        end
    end

    // cmd_valid comes from state so an asynchronous reset drops it at once.
    assign cmd_valid    = (state_q == StIssue);
    assign cmd_op       = op_q;
    assign cmd_player   = player_q;
    assign cmd_coord    = coord_q;
    assign phase        = state_q;
    assign turn         = turn_q;
    assign last_hit     = last_hit_q;
    assign scoreA       = score_a_q;
    assign scoreB       = score_b_q;
    assign winner_valid = win_valid_q;
    assign winner       = win_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench for turn_scheduler against a rule-level game model.
module tb_turn_scheduler;
    import battleship_pkg::*;

    localparam int SHIPS = 4;
    localparam int WIN   = 4;
    localparam int SHOW  = 50;
    localparam int TO    = 10;

    localparam int P_IDLE  = int'(StIdle);
    localparam int P_PLACE = int'(StPlace);
    localparam int P_SHOT  = int'(StShot);
    localparam int P_WAIT  = int'(StWaitRsp);
    localparam int P_SHOW  = int'(StShow);
    localparam int P_DONE  = int'(StDone);

    logic       clk, rst, start, pA_req, pB_req, cmd_ready, rsp_valid;
    logic [3:0] coord;
    logic [1:0] rsp_code;
    logic       cmd_valid, cmd_op, cmd_player, turn, last_hit, winner_valid, winner;
    logic [3:0] cmd_coord;
    logic [2:0] phase, scoreA, scoreB;

    turn_scheduler #(
        .SHIPS      (SHIPS),
        .WIN_SCORE  (WIN),
        .SHOW_CYC   (SHOW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pA_req      (pA_req),
        .pB_req      (pB_req),
        .coord       (coord),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_player  (cmd_player),
        .cmd_coord   (cmd_coord),
        .rsp_valid   (rsp_valid),
        .rsp_code    (rsp_code),
        .phase       (phase),
        .turn        (turn),
        .last_hit    (last_hit),
        .scoreA      (scoreA),
        .scoreB      (scoreB),
        .winner_valid(winner_valid),
        .winner      (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;

    // Count completed command handshakes.
    always @(posedge clk) if (cmd_valid && cmd_ready) hs_cnt <= hs_cnt + 1;

    // Game model.
    int m_phase;
    bit m_turn, m_shoot, m_last_hit, m_win_v, m_win;
    int m_places[2];
    int m_score[2];

    logic [12:0] obs_vec;
    logic [6:0]  cmd_vec;
    assign obs_vec = {phase, turn, scoreA, scoreB, last_hit, winner_valid, winner};
    assign cmd_vec = {cmd_valid, cmd_op, cmd_player, cmd_coord};

    function automatic logic [12:0] exp_vec();
        return {3'(m_phase), m_turn, 3'(m_score[0]), 3'(m_score[1]), m_last_hit, m_win_v, m_win};
    endfunction

    function void model_reset();
        m_phase = P_IDLE; m_turn = 0; m_shoot = 0; m_last_hit = 0; m_win_v = 0; m_win = 0;
        m_places[0] = 0; m_places[1] = 0; m_score[0] = 0; m_score[1] = 0;
    endfunction

    function void model_start();
        model_reset();
        m_phase = P_PLACE;
    endfunction

    function void model_rsp(input int code);
        if (!m_shoot) begin
            m_phase = P_PLACE;
            if (code == 0) begin
                m_places[m_turn]++;
                if (m_places[m_turn] == SHIPS) begin
                    if (m_turn == 0) m_turn = 1;
                    else begin m_shoot = 1; m_turn = 0; m_phase = P_SHOT; end
                end
            end
        end else if (code == 1) begin
            m_last_hit = 1;
            if (m_score[m_turn] < 7) m_score[m_turn]++;
            if (m_score[m_turn] == WIN) begin
                m_win_v = 1; m_win = m_turn; m_phase = P_DONE;
            end else m_phase = P_SHOW;
        end else if (code == 0) begin
            m_last_hit = 0; m_phase = P_SHOW;
        end else m_phase = P_SHOT;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    // One full turn: request, handshake with backpressure, response, result hold.
    task automatic run_turn(input string tag, input logic [3:0] c, input int code,
                            input int rwait, input bit wrong_first, input bit both);
        bit p;
        int hs0;
        int n;
        logic [6:0] exp_cmd;
        p = m_turn;
        if (wrong_first) begin
            if (p) pA_req = 1; else pB_req = 1;
            coord = ~c;
            tick();
            pA_req = 0; pB_req = 0;
            n_tests++;
            if (cmd_valid !== 1'b0) begin
                n_fail++; $display("FAIL %s_drop_other: cmd_valid got %b want 0", tag, cmd_valid);
            end
        end
        coord = c;
        if (p || both) pB_req = 1;
        if (!p || both) pA_req = 1;
        tick();
        pA_req = 0; pB_req = 0; coord = 4'($urandom);
        exp_cmd = {1'b1, m_shoot, p, c};
        n_tests++;
        if (cmd_vec !== exp_cmd) begin
            n_fail++; $display("FAIL %s_cmd: got %h want %h", tag, cmd_vec, exp_cmd);
        end
        hs0 = hs_cnt;
        for (int i = 0; i < rwait; i++) begin
            cmd_ready = 0;
            rsp_valid = (i == 0); rsp_code = 2'b01;  // stray response outside WAIT_RSP
            tick();
            rsp_valid = 0;
            n_tests++;
            if (cmd_vec !== exp_cmd) begin
                n_fail++; $display("FAIL %s_stable%0d: got %h want %h", tag, i, cmd_vec, exp_cmd);
            end
        end
        cmd_ready = 1;
        tick();
        cmd_ready = 0;
        n_tests++;
        if (phase !== 3'(P_WAIT) || cmd_valid !== 1'b0 || hs_cnt != hs0 + 1) begin
            n_fail++;
            $display("FAIL %s_handshake: phase %0d valid %b hs %0d want phase %0d valid 0 hs %0d",
                     tag, phase, cmd_valid, hs_cnt - hs0, P_WAIT, 1);
        end
        rsp_valid = 1; rsp_code = 2'(code);
        tick();
        rsp_valid = 0;
        model_rsp(code);
        n_tests++;
        if (obs_vec !== exp_vec()) begin
            n_fail++; $display("FAIL %s_rsp: got %h want %h", tag, obs_vec, exp_vec());
        end
        if (m_phase == P_SHOW) begin
            n = 1;
            while (phase == 3'(P_SHOW) && n < 200) begin
                tick();
                if (phase == 3'(P_SHOW)) n++;
            end
            n_tests++;
            if (n != SHOW) begin
                n_fail++; $display("FAIL %s_show_len: got %0d want %0d", tag, n, SHOW);
            end
            m_phase = P_SHOT; m_turn = !m_turn;
            n_tests++;
            if (obs_vec !== exp_vec()) begin
                n_fail++; $display("FAIL %s_after_show: got %h want %h", tag, obs_vec, exp_vec());
            end
        end
    endtask

    task automatic test_reset();
        rst = 0; start = 0; pA_req = 0; pB_req = 0; coord = 0;
        cmd_ready = 0; rsp_valid = 0; rsp_code = 0;
        model_reset();
        tick(); tick();
        n_tests++;
        if (obs_vec !== exp_vec() || cmd_vec !== 7'd0) begin
            n_fail++; $display("FAIL reset_values: got %h/%h want %h/0", obs_vec, cmd_vec, exp_vec());
        end
        #2 rst = 1;
        tick();
        pA_req = 1; tick(); pA_req = 0;
        n_tests++;
        if (phase !== 3'(P_IDLE) || cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_ignores_req: phase %0d valid %b want 0 0", phase, cmd_valid);
        end
    endtask

    task automatic test_placement();
        int guard;
        pulse_start();
        model_start();
        n_tests++;
        if (obs_vec !== exp_vec()) begin
            n_fail++; $display("FAIL start_place: got %h want %h", obs_vec, exp_vec());
        end
        guard = 0;
        while (!m_shoot && guard < 40) begin
            if (m_turn && m_places[1] == 0 && guard < 20) begin
                // A's pulses during B placement must not produce a command.
                pA_req = 1;
                for (int i = 0; i < 3; i++) begin
                    tick();
                    n_tests++;
                    if (cmd_valid !== 1'b0) begin
                        n_fail++; $display("FAIL place_wrong_player: cmd_valid got %b want 0", cmd_valid);
                    end
                end
                pA_req = 0;
                guard = 20;
            end
            run_turn("place", 4'($urandom),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 3)) : 0,
                     int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
            guard++;
        end
    endtask

    task automatic test_hit_miss_illegal();
        run_turn("simul_backpressure_hit", 4'b1001, 1, 5, 1'b0, 1'b1);
        run_turn("b_illegal", 4'b0110, 2, 0, 1'b0, 1'b0);
        run_turn("b_miss", 4'b0011, 0, 1, 1'b1, 1'b0);
    endtask

    task automatic test_random_game();
        int r, code;
        for (int k = 0; k < 80 && !m_win_v; k++) begin
            r = int'($urandom_range(0, 5));
            code = (r < 2) ? 0 : (r < 4) ? 1 : r - 2;
            run_turn("rand", 4'($urandom), code, int'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom));
        end
        for (int k = 0; k < 20 && !m_win_v; k++) begin
            run_turn("rand_finish", 4'($urandom), 1, 0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_win();
        int hs0;
        hs0 = hs_cnt;
        pA_req = 1; pB_req = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (obs_vec !== exp_vec() || cmd_valid !== 1'b0) begin
                n_fail++; $display("FAIL done_hold: got %h valid %b want %h valid 0",
                                   obs_vec, cmd_valid, exp_vec());
            end
        end
        pA_req = 0; pB_req = 0;
        pulse_start();
        model_start();
        n_tests++;
        if (obs_vec !== exp_vec() || hs_cnt != hs0) begin
            n_fail++; $display("FAIL restart: got %h want %h", obs_vec, exp_vec());
        end
        for (int i = 0; i < 2 * SHIPS; i++) run_turn("win_place", 4'(i), 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < WIN && !m_win_v; k++) begin
            run_turn("win_a_hit", 4'($urandom), 1, 0, 1'b0, 1'b0);
            if (!m_win_v) run_turn("win_b_miss", 4'($urandom), 0, 0, 1'b0, 1'b0);
        end
        n_tests++;
        if (winner_valid !== 1'b1 || winner !== 1'b0 || scoreA !== 3'(WIN)) begin
            n_fail++; $display("FAIL a_wins: valid %b winner %b scoreA %0d want 1 0 %0d",
                               winner_valid, winner, scoreA, WIN);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        model_start();
        pA_req = 1; coord = 4'hA; tick(); pA_req = 0;
        n_tests++;
        if (cmd_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_issue_valid: got %b want 1", cmd_valid);
        end
        #2 rst = 0;
        #1;
        model_reset();
        n_tests++;
        if (cmd_vec !== 7'd0 || obs_vec !== exp_vec()) begin
            n_fail++; $display("FAIL reset_in_issue: got %h/%h want 0/%h", cmd_vec, obs_vec, exp_vec());
        end
        #2 rst = 1;
        tick();
        pulse_start();
        model_start();
        pA_req = 1; coord = 4'h5; tick(); pA_req = 0;
        cmd_ready = 1; tick(); cmd_ready = 0;
        #2 rst = 0;
        #1;
        model_reset();
        n_tests++;
        if (cmd_vec !== 7'd0 || obs_vec !== exp_vec()) begin
            n_fail++; $display("FAIL reset_in_wait: got %h/%h want 0/%h", cmd_vec, obs_vec, exp_vec());
        end
        #2 rst = 1;
        tick();
    endtask

`ifdef SHOT_TIMEOUT_EN
    task automatic test_timeout();
        int hs0, n;
        bit t0;
        pulse_start();
        model_start();
        for (int i = 0; i < 2 * SHIPS; i++) run_turn("to_place", 4'(i), 0, 0, 1'b0, 1'b0);
        for (int round = 0; round < 2; round++) begin
            hs0 = hs_cnt;
            t0 = turn;
            n = 0;
            while (turn == t0 && n < 100) begin
                tick();
                n++;
            end
            m_turn = !m_turn;
            n_tests++;
            if (n != TO || hs_cnt != hs0 || obs_vec !== exp_vec()) begin
                n_fail++; $display("FAIL timeout%0d: cycles %0d cmds %0d state %h want %0d 0 %h",
                                   round, n, hs_cnt - hs0, obs_vec, TO, exp_vec());
            end
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_placement();
        test_hit_miss_illegal();
        test_random_game();
        test_win();
        test_reset_mid();
`ifdef SHOT_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
